window_sr: RTL and testbench
============================

Name: window_sr

Overview:
- Parametrised parallel-out shift register that buffers the most recent DEPTH samples of a stream. All samples are exposed on a flat bus for the convolution window datapath.
- Adds the following over the fixed 8-bit shift unit chain:
  - configurable data width
  - shift enable
  - synchronous clear
  - parallel load
  - fill tracking
  - a registered eviction port so instances can be cascaded into multi-row line buffers.

Parameters:
- WIDTH, 8, bits per sample; must be at least 1.
- DEPTH, 9, number of stages; must be at least 1.
- CW, $clog2(DEPTH+1), width of fill_count. Derived; must not be overridden.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- clear  input  1  synchronous clear of contents and fill state
- load_en  input  1  parallel load strobe
- p_in  input  WIDTH*DEPTH  parallel load data; slice i = p_in[(i+1)*WIDTH-1 : i*WIDTH] goes to stage i
- shift_en  input  1  shift strobe
- shift_in  input  WIDTH  sample entering stage 0
- p_out  output  WIDTH*DEPTH  slice i = stage i; stage 0 holds the newest sample
- shift_out  output  WIDTH  stage DEPTH-1, the oldest sample; a direct register view
- fill_count  output  CW  number of valid stages, 0..DEPTH
- full  output  1  fill_count == DEPTH; registered
- evict_data  output  WIDTH  sample pushed out of stage DEPTH-1 on the last qualifying shift
- evict_valid  output  1  one-cycle pulse qualifying evict_data

Behaviour:
- Reset (asynchronous, active-low) sets every stage, fill_count, full, evict_data and evict_valid to 0. Reset asserted mid-stream discards contents immediately, without waiting for a clock edge.
- All state updates on the rising edge of clock. Command priority each cycle is clear > load_en > shift_en.
- clear:
  - all stages, fill_count, full and evict_valid go to 0;
  - evict_data holds its value;
  - load_en and shift_en in the same cycle are ignored.
- load_en (clear low):
  - stage i <= p_in slice i;
  - fill_count <= DEPTH, full <= 1;
  - evict_valid <= 0;
  - a simultaneous shift_en is ignored, so no shift and no eviction occur.
- shift_en (clear and load_en low):
  - stage 0 <= shift_in;
  - stage i <= stage i-1 for 1 <= i < DEPTH;
  - fill_count <= min(fill_count+1, DEPTH), saturating;
  - full <= (new fill_count == DEPTH).
- Eviction:
  - on a shift while full == 1 before the edge, evict_data <= old stage DEPTH-1 and evict_valid <= 1;
  - on a shift while not full, evict_valid <= 0 and evict_data holds.
- Idle (no command): stages, fill_count and full hold; evict_valid <= 0. evict_valid is never high for two cycles unless shifts occur back-to-back while full.
- Latency:
  - shift_in appears on p_out slice 0 one cycle after the shift;
  - it appears on shift_out DEPTH cycles of shift_en later.
- DEPTH=1:
  - p_out == shift_out;
  - the first shift sets full;
  - every later shift evicts the previous sample.
- Sequential logic is limited to the stage array, the fill counter, full, and the eviction registers. p_out and shift_out are wires from the stage registers with no added logic.
- Interface rule: cascading is done by connecting evict_data and evict_valid of one instance to shift_in and shift_en of the next.

Test Plan:
- Reset, then 4 shifts of 0x11, 0x22, 0x33, 0x44 (WIDTH=8, DEPTH=4):
  - p_out = 0x11223344, i.e. stage 3 = 0x11 and stage 0 = 0x44;
  - fill_count steps 1, 2, 3, 4;
  - full rises after the 4th edge;
  - evict_valid stays 0 throughout.
- Continue with a 5th shift of 0x55:
  - p_out = 0x22334455;
  - evict_data = 0x11 with evict_valid high for exactly 1 cycle;
  - fill_count stays at 4.
- shift_en toggled 1,0,1 from empty with 0xAA then 0xBB:
  - fill_count = 2 and p_out slice 0 = 0xBB, slice 1 = 0xAA;
  - no change to p_out or fill_count in the idle cycle.
- load_en and shift_en together with p_in = 0xDEADBEEF:
  - p_out = 0xDEADBEEF, full = 1, evict_valid = 0;
  - shift_in is ignored.
- clear, load_en and shift_en together while full:
  - p_out = 0, fill_count = 0, full = 0;
  - evict_data keeps its prior value.
- reset pulsed low between clock edges mid-stream:
  - all outputs go to 0 before the next rising edge;
  - the first shift after release gives fill_count = 1.
- DEPTH=1 instance with 3 shifts 0x01, 0x02, 0x03:
  - evictions of 0x01 then 0x02;
  - shift_out = 0x03.

Source files
------------

// File: rtl/window_sr.sv
// Parallel-out shift register holding the last DEPTH samples of a stream,
// with clear, parallel load, fill tracking and a registered eviction port.
module window_sr #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 9,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   load_en,
  input  logic [WIDTH*DEPTH-1:0] p_in,
  input  logic                   shift_en,
  input  logic [WIDTH-1:0]       shift_in,
  output logic [WIDTH*DEPTH-1:0] p_out,
  output logic [WIDTH-1:0]       shift_out,
  output logic [CW-1:0]          fill_count,
  output logic                   full,
  output logic [WIDTH-1:0]       evict_data,
  output logic                   evict_valid
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] ev_data_q, ev_data_d;
  logic             ev_vld_q, ev_vld_d;

  always_comb begin
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    ev_data_d = ev_data_q;
    ev_vld_d  = 1'b0;
    priority case (1'b1)
      clear: begin
        for (int i = 0; i < DEPTH; i++)
          stage_d[i] = '0;
        cnt_d  = '0;
        full_d = 1'b0;
      end
      load_en: begin
        for (int i = 0; i < DEPTH; i++)
          stage_d[i] = p_in[i*WIDTH +: WIDTH];
        cnt_d  = DEPTH_C;
        full_d = 1'b1;
      end
      shift_en: begin
        stage_d[0] = shift_in;
        for (int i = 1; i < DEPTH; i++)
          stage_d[i] = stage_q[i-1];
        // Only a full window pushes a real sample out of the last stage
        if (full_q) begin
          ev_data_d = stage_q[DEPTH-1];
          ev_vld_d  = 1'b1;
        end
        if (cnt_q != DEPTH_C)
          cnt_d = cnt_q + CW'(1);
        full_d = (cnt_d == DEPTH_C);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        stage_q[i] <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      ev_data_q <= '0;
      ev_vld_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        stage_q[i] <= stage_d[i];
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      ev_data_q <= ev_data_d;
      ev_vld_q  <= ev_vld_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pout
    assign p_out[g*WIDTH +: WIDTH] = stage_q[g];
  end

  assign shift_out   = stage_q[DEPTH-1];
  assign fill_count  = cnt_q;
  assign full        = full_q;
  assign evict_data  = ev_data_q;
  assign evict_valid = ev_vld_q;

endmodule

// File: tb/tb_window_sr.sv
// Bench for window_sr: directed steps plus random traffic on a
// DEPTH=4 and a DEPTH=1 instance, checked against a queue model.
module tb_window_sr;

  logic        clock, reset;
  logic        clr0, ld0, sh0;
  logic [31:0] pin0;
  logic [7:0]  sin0;
  logic [31:0] pout0;
  logic [7:0]  sout0, ed0o;
  logic [2:0]  fc0;
  logic        full0, ev0o;

  logic        clr1, ld1, sh1;
  logic [7:0]  pin1, sin1;
  logic [7:0]  pout1, sout1, ed1o;
  logic [0:0]  fc1;
  logic        full1, ev1o;

  int checks = 0;
  int errors = 0;

  window_sr #(.WIDTH(8), .DEPTH(4)) u0 (
    .clock(clock), .reset(reset), .clear(clr0), .load_en(ld0),
    .p_in(pin0), .shift_en(sh0), .shift_in(sin0), .p_out(pout0),
    .shift_out(sout0), .fill_count(fc0), .full(full0),
    .evict_data(ed0o), .evict_valid(ev0o)
  );

  window_sr #(.WIDTH(8), .DEPTH(1)) u1 (
    .clock(clock), .reset(reset), .clear(clr1), .load_en(ld1),
    .p_in(pin1), .shift_en(sh1), .shift_in(sin1), .p_out(pout1),
    .shift_out(sout1), .fill_count(fc1), .full(full1),
    .evict_data(ed1o), .evict_valid(ev1o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model: queue index 0 is the newest sample
  logic [7:0] m0[$];
  int         c0;
  logic [7:0] med0;
  bit         mev0;
  logic [7:0] m1;
  int         c1;
  logic [7:0] med1;
  bit         mev1;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m0.delete();
    repeat (4) m0.push_back(8'h00);
    c0 = 0; med0 = 0; mev0 = 0;
    m1 = 0; c1 = 0; med1 = 0; mev1 = 0;
  endtask

  task automatic model_step();
    if (clr0) begin
      foreach (m0[i]) m0[i] = 8'h00;
      c0 = 0; mev0 = 0;
    end else if (ld0) begin
      foreach (m0[i]) m0[i] = pin0[i*8 +: 8];
      c0 = 4; mev0 = 0;
    end else if (sh0) begin
      mev0 = (c0 == 4);
      if (mev0) med0 = m0[3];
      m0.push_front(sin0);
      void'(m0.pop_back());
      c0 = (c0 < 4) ? c0 + 1 : 4;
    end else mev0 = 0;
    if (clr1) begin
      m1 = 0; c1 = 0; mev1 = 0;
    end else if (ld1) begin
      m1 = pin1; c1 = 1; mev1 = 0;
    end else if (sh1) begin
      mev1 = (c1 == 1);
      if (mev1) med1 = m1;
      m1 = sin1; c1 = 1;
    end else mev1 = 0;
  endtask

  task automatic compare_all();
    logic [31:0] ep;
    for (int i = 0; i < 4; i++) ep[i*8 +: 8] = m0[i];
    chk("p_out0", 64'(pout0), 64'(ep));
    chk("shift_out0", 64'(sout0), 64'(m0[3]));
    chk("fill0", 64'(fc0), 64'(c0));
    chk("full0", 64'(full0), 64'(c0 == 4));
    chk("evv0", 64'(ev0o), 64'(mev0));
    chk("evd0", 64'(ed0o), 64'(med0));
    chk("p_out1", 64'(pout1), 64'(m1));
    chk("shift_out1", 64'(sout1), 64'(m1));
    chk("fill1", 64'(fc1), 64'(c1));
    chk("full1", 64'(full1), 64'(c1 == 1));
    chk("evv1", 64'(ev1o), 64'(mev1));
    chk("evd1", 64'(ed1o), 64'(med1));
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    model_step();
    compare_all();
  endtask

  task automatic idle();
    clr0 = 0; ld0 = 0; sh0 = 0;
    clr1 = 0; ld1 = 0; sh1 = 0;
  endtask

  task automatic shift0(logic [7:0] d);
    idle();
    sh0 = 1; sin0 = d;
    cyc();
  endtask

  task automatic shift1(logic [7:0] d);
    idle();
    sh1 = 1; sin1 = d;
    cyc();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    pin0 = 0; sin0 = 0; pin1 = 0; sin1 = 0;
    model_reset();
    #12;
    compare_all();
    reset = 1'b1;

    shift0(8'h11);
    chk("fc_step1", 64'(fc0), 64'd1);
    shift0(8'h22);
    chk("fc_step2", 64'(fc0), 64'd2);
    shift0(8'h33);
    chk("full_before", 64'(full0), 64'd0);
    shift0(8'h44);
    chk("p_out_4", 64'(pout0), 64'h11223344);
    chk("full_after4", 64'(full0), 64'd1);
    chk("evv_none", 64'(ev0o), 64'd0);
    shift0(8'h55);
    chk("p_out_5", 64'(pout0), 64'h22334455);
    chk("evict_11", 64'(ed0o), 64'h11);
    chk("evv_5", 64'(ev0o), 64'd1);
    chk("fc_sat", 64'(fc0), 64'd4);
    idle();
    cyc();
    chk("evv_pulse", 64'(ev0o), 64'd0);

    idle(); clr0 = 1;
    cyc();
    shift0(8'hAA);
    idle();
    cyc();
    chk("idle_fc", 64'(fc0), 64'd1);
    chk("idle_pout", 64'(pout0[7:0]), 64'hAA);
    shift0(8'hBB);
    chk("tog_fc", 64'(fc0), 64'd2);
    chk("tog_pout", 64'(pout0[15:0]), 64'hAABB);

    idle(); ld0 = 1; sh0 = 1; pin0 = 32'hDEADBEEF; sin0 = 8'h77;
    cyc();
    chk("load_pout", 64'(pout0), 64'hDEADBEEF);
    chk("load_full", 64'(full0), 64'd1);
    chk("load_evv", 64'(ev0o), 64'd0);
    shift0(8'h66);
    chk("evict_de", 64'(ed0o), 64'hDE);

    idle(); clr0 = 1; ld0 = 1; sh0 = 1;
    cyc();
    chk("clr_pout", 64'(pout0), 64'd0);
    chk("clr_fc", 64'(fc0), 64'd0);
    chk("clr_ed", 64'(ed0o), 64'hDE);

    shift0(8'h12);
    shift0(8'h34);
    #3 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("arst_pout", 64'(pout0), 64'd0);
    #2 reset = 1'b1;
    shift0(8'h9C);
    chk("post_rst_fc", 64'(fc0), 64'd1);

    shift1(8'h01);
    chk("d1_full", 64'(full1), 64'd1);
    chk("d1_evv0", 64'(ev1o), 64'd0);
    shift1(8'h02);
    chk("d1_ev1", 64'(ed1o), 64'h01);
    shift1(8'h03);
    chk("d1_ev2", 64'(ed1o), 64'h02);
    chk("d1_sout", 64'(sout1), 64'h03);

    for (int n = 0; n < 400; n++) begin
      clr0 = ($urandom_range(0, 29) == 0);
      ld0  = ($urandom_range(0, 11) == 0);
      sh0  = ($urandom_range(0, 3) != 0);
      pin0 = $urandom;
      sin0 = 8'($urandom);
      clr1 = ($urandom_range(0, 29) == 0);
      ld1  = ($urandom_range(0, 11) == 0);
      sh1  = ($urandom_range(0, 2) != 0);
      pin1 = 8'($urandom);
      sin1 = 8'($urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
